// File: rtl/watch_pkg.sv
// ----------------------------------------------------------------------------
// watch_pkg
// Shared types and limits for the BCD timekeeper.
//   bcd_t        : one BCD digit (4 bits)
//   time_t       : packed hh:mm:ss digits plus PM flag
//   hour_mode_e  : 24-hour or 12-hour (AM/PM) counting
//   *_MAX/_MIN   : digit and hour limits used by the cascade and load checks
//   tens_units_ok / hour_ok : legality checks for loaded digit pairs
// ----------------------------------------------------------------------------
package watch_pkg;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t h10;
      bcd_t h1;
      bcd_t m10;
      bcd_t m1;
      bcd_t s10;
      bcd_t s1;
      logic pm;
   } time_t;

   typedef enum logic {
      HOUR_24 = 1'b0,
      HOUR_12 = 1'b1
   } hour_mode_e;

   localparam bcd_t       SEC_TENS_MAX = 4'd5;
   localparam bcd_t       UNITS_MAX    = 4'd9;
   localparam logic [7:0] HOUR24_MAX   = 8'd23;
   localparam logic [7:0] HOUR12_MIN   = 8'd1;
   localparam logic [7:0] HOUR12_MAX   = 8'd12;

   // Seconds/minutes pair: tens 0..5, units 0..9.
   function automatic logic tens_units_ok(bcd_t tens, bcd_t units);
      return (tens <= SEC_TENS_MAX) && (units <= UNITS_MAX);
   endfunction

   // Hour pair legal for the selected mode (00..23 or 01..12).
   function automatic logic hour_ok(hour_mode_e mode, bcd_t h10, bcd_t h1);
      logic [7:0] hv;
      if ((h10 > UNITS_MAX) || (h1 > UNITS_MAX))
         return 1'b0;
      hv = ({4'd0, h10} * 8'd10) + {4'd0, h1};
      if (mode == HOUR_24)
         return hv <= HOUR24_MAX;
      return (hv >= HOUR12_MIN) && (hv <= HOUR12_MAX);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Prescaler producing one tick every CLK_DIV enabled clock cycles.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears the count
//   en   : count enable; 0 freezes the count and suppresses tick
//   clr  : synchronous clear (restarts the second); suppresses tick
//   tick : high for the cycle in which the count sits at CLK_DIV-1
// ----------------------------------------------------------------------------
module tick_gen #(
   parameter int unsigned CLK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned          CNT_W   = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic             at_max;

   assign at_max = (cnt == CNT_MAX);

   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= at_max ? '0 : cnt + CNT_W'(1);
   end

   // A cleared second never reports its wrap, so a load discards it.
   assign tick = en && at_max && !clr;

endmodule

// File: rtl/bcd_timekeeper.sv
// ----------------------------------------------------------------------------
// bcd_timekeeper
// BCD hh:mm:ss clock with 24h or 12h (AM/PM) counting and checked time load.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   en                  : count enable (freezes prescaler and time when 0)
//   load, ld_*          : one-cycle time-set strobe and BCD digits to load
//   ld_pm               : PM flag to load (12h mode only)
//   hour_10..sec1, pm   : registered BCD time and PM flag
//   tick_1hz            : one-cycle pulse per elapsed second
//   load_err            : one-cycle pulse when a load carried illegal digits
// ----------------------------------------------------------------------------
module bcd_timekeeper
   import watch_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 50_000_000,
   parameter bit          MODE_12H = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic [3:0] ld_hour_10,
   input  logic [3:0] ld_hour1,
   input  logic [3:0] ld_min_10,
   input  logic [3:0] ld_min1,
   input  logic [3:0] ld_sec_10,
   input  logic [3:0] ld_sec1,
   input  logic       ld_pm,
   output logic [3:0] hour_10,
   output logic [3:0] hour1,
   output logic [3:0] min_10,
   output logic [3:0] min1,
   output logic [3:0] sec_10,
   output logic [3:0] sec1,
   output logic       pm,
   output logic       tick_1hz,
   output logic       load_err
);

   localparam hour_mode_e MODE = MODE_12H ? HOUR_12 : HOUR_24;

   // Midnight shows as 12:00:00 AM in 12h mode.
   localparam time_t RST_TIME = '{
      h10: (MODE == HOUR_12) ? 4'd1 : 4'd0,
      h1 : (MODE == HOUR_12) ? 4'd2 : 4'd0,
      m10: 4'd0, m1: 4'd0, s10: 4'd0, s1: 4'd0, pm: 1'b0
   };

   time_t cur_q;
   time_t nxt;
   time_t ld_time;
   logic  load_ok;
   logic  load_acc;
   logic  sec_wrap;
   logic  min_wrap;

   // ---------------- load check ----------------
   assign load_ok  = tens_units_ok(ld_sec_10, ld_sec1)
                  && tens_units_ok(ld_min_10, ld_min1)
                  && hour_ok(MODE, ld_hour_10, ld_hour1);
   assign load_acc = load && load_ok;

   assign ld_time = '{
      h10: ld_hour_10, h1: ld_hour1,
      m10: ld_min_10,  m1: ld_min1,
      s10: ld_sec_10,  s1: ld_sec1,
      pm : (MODE == HOUR_12) ? ld_pm : 1'b0
   };

   // ---------------- prescaler ----------------
   tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick_gen (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .clr (load_acc),
      .tick(tick_1hz)
   );

   // ---------------- digit cascade ----------------
   assign sec_wrap = (cur_q.s10 == SEC_TENS_MAX) && (cur_q.s1 == UNITS_MAX);
   assign min_wrap = (cur_q.m10 == SEC_TENS_MAX) && (cur_q.m1 == UNITS_MAX);

   // NOTE: nxt starts as a full copy of cur_q so every path assigns every
   // field; without that default this block would infer latches.
   always_comb begin
      nxt = cur_q;

      if (cur_q.s1 == UNITS_MAX) begin
         nxt.s1  = '0;
         nxt.s10 = sec_wrap ? '0 : cur_q.s10 + 4'd1;
      end else begin
         nxt.s1 = cur_q.s1 + 4'd1;
      end

      if (sec_wrap) begin
         if (cur_q.m1 == UNITS_MAX) begin
            nxt.m1  = '0;
            nxt.m10 = min_wrap ? '0 : cur_q.m10 + 4'd1;
         end else begin
            nxt.m1 = cur_q.m1 + 4'd1;
         end
      end

      if (sec_wrap && min_wrap) begin
         if (MODE == HOUR_24) begin
            if (cur_q.h10 == 4'd2 && cur_q.h1 == 4'd3) begin
               nxt.h10 = '0;
               nxt.h1  = '0;
            end else if (cur_q.h1 == UNITS_MAX) begin
               nxt.h10 = cur_q.h10 + 4'd1;
               nxt.h1  = '0;
            end else begin
               nxt.h1 = cur_q.h1 + 4'd1;
            end
         end else begin
            // 12h: 11 -> 12 flips AM/PM, 12 -> 01 keeps it.
            if (cur_q.h10 == 4'd1 && cur_q.h1 == 4'd1) begin
               nxt.h1 = 4'd2;
               nxt.pm = ~cur_q.pm;
            end else if (cur_q.h10 == 4'd1 && cur_q.h1 == 4'd2) begin
               nxt.h10 = '0;
               nxt.h1  = 4'd1;
            end else if (cur_q.h1 == UNITS_MAX) begin
               nxt.h10 = 4'd1;
               nxt.h1  = '0;
            end else begin
               nxt.h1 = cur_q.h1 + 4'd1;
            end
         end
      end
   end

   // ---------------- time register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q    <= RST_TIME;
         load_err <= 1'b0;
      end else begin
         load_err <= load && !load_ok;
         if (load_acc)
            cur_q <= ld_time;
         else if (tick_1hz)
            cur_q <= nxt;
      end
   end

   assign hour_10 = cur_q.h10;
   assign hour1   = cur_q.h1;
   assign min_10  = cur_q.m10;
   assign min1    = cur_q.m1;
   assign sec_10  = cur_q.s10;
   assign sec1    = cur_q.s1;
   assign pm      = cur_q.pm;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// ----------------------------------------------------------------------------
// tb_bcd_timekeeper
// Runs a 24h and a 12h instance (CLK_DIV=4) side by side on shared stimulus.
// The reference keeps time as seconds since midnight and derives the
// displayed digits from it.
// ----------------------------------------------------------------------------
module tb_bcd_timekeeper;

   localparam int DIV = 4;
   localparam int DAY = 86400;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, load, ld_pm;
   logic [3:0] ld_h10, ld_h1, ld_m10, ld_m1, ld_s10, ld_s1;

   logic [3:0] h10_a, h1_a, m10_a, m1_a, s10_a, s1_a;
   logic       pm_a, tick_a, err_a;
   logic [3:0] h10_b, h1_b, m10_b, m1_b, s10_b, s1_b;
   logic       pm_b, tick_b, err_b;

   bcd_timekeeper #(.CLK_DIV(DIV), .MODE_12H(1'b0)) dut_24 (
      .clk(clk), .rst(rst), .en(en), .load(load),
      .ld_hour_10(ld_h10), .ld_hour1(ld_h1), .ld_min_10(ld_m10),
      .ld_min1(ld_m1), .ld_sec_10(ld_s10), .ld_sec1(ld_s1), .ld_pm(ld_pm),
      .hour_10(h10_a), .hour1(h1_a), .min_10(m10_a), .min1(m1_a),
      .sec_10(s10_a), .sec1(s1_a), .pm(pm_a),
      .tick_1hz(tick_a), .load_err(err_a)
   );

   bcd_timekeeper #(.CLK_DIV(DIV), .MODE_12H(1'b1)) dut_12 (
      .clk(clk), .rst(rst), .en(en), .load(load),
      .ld_hour_10(ld_h10), .ld_hour1(ld_h1), .ld_min_10(ld_m10),
      .ld_min1(ld_m1), .ld_sec_10(ld_s10), .ld_sec1(ld_s1), .ld_pm(ld_pm),
      .hour_10(h10_b), .hour1(h1_b), .min_10(m10_b), .min1(m1_b),
      .sec_10(s10_b), .sec1(s1_b), .pm(pm_b),
      .tick_1hz(tick_b), .load_err(err_b)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference state, index 0 = 24h instance, 1 = 12h instance.
   int t_m[2];
   int presc_m[2];
   bit err_m[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // {h10,h1,m10,m1,s10,s1,pm} as a 25-bit word.
   function automatic logic [31:0] pack(int hh, int mm, int ss, bit p);
      return {7'd0, 4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
              4'(ss / 10), 4'(ss % 10), p};
   endfunction

   function automatic logic [31:0] observed(int m);
      if (m == 0)
         return {7'd0, h10_a, h1_a, m10_a, m1_a, s10_a, s1_a, pm_a};
      return {7'd0, h10_b, h1_b, m10_b, m1_b, s10_b, s1_b, pm_b};
   endfunction

   function automatic logic [31:0] expected(int m);
      int hh, hd;
      hh = t_m[m] / 3600;
      if (m == 0)
         return pack(hh, (t_m[m] / 60) % 60, t_m[m] % 60, 1'b0);
      hd = (hh % 12 == 0) ? 12 : hh % 12;
      return pack(hd, (t_m[m] / 60) % 60, t_m[m] % 60, hh >= 12);
   endfunction

   function automatic bit load_valid(int m);
      int hv;
      if (ld_s10 > 5 || ld_s1 > 9 || ld_m10 > 5 || ld_m1 > 9 || ld_h10 > 9 || ld_h1 > 9)
         return 1'b0;
      hv = 10 * ld_h10 + ld_h1;
      return (m == 0) ? (hv <= 23) : (hv >= 1 && hv <= 12);
   endfunction

   function automatic int load_secs(int m);
      int hv;
      hv = 10 * ld_h10 + ld_h1;
      if (m == 1)
         hv = (hv % 12) + (ld_pm ? 12 : 0);
      return hv * 3600 + (10 * ld_m10 + ld_m1) * 60 + 10 * ld_s10 + ld_s1;
   endfunction

   // Compare outputs mid-cycle, then advance the reference over the edge.
   task automatic step();
      bit acc, tk;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         acc = load && load_valid(m);
         tk  = en && (presc_m[m] == DIV - 1) && !acc;
         check($sformatf("m%0d time", m), observed(m), expected(m));
         check($sformatf("m%0d tick", m), {31'd0, (m == 0) ? tick_a : tick_b}, {31'd0, tk});
         check($sformatf("m%0d load_err", m), {31'd0, (m == 0) ? err_a : err_b}, {31'd0, err_m[m]});
         if (rst) begin
            t_m[m] = 0; presc_m[m] = 0; err_m[m] = 1'b0;
         end else begin
            err_m[m] = load && !load_valid(m);
            if (acc) begin
               t_m[m] = load_secs(m); presc_m[m] = 0;
            end else if (en) begin
               if (presc_m[m] == DIV - 1) begin
                  presc_m[m] = 0;
                  t_m[m] = (t_m[m] + 1) % DAY;
               end else begin
                  presc_m[m]++;
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_ld(int a, int b, int c, int d, int e, int f, bit p);
      ld_h10 = 4'(a); ld_h1 = 4'(b); ld_m10 = 4'(c);
      ld_m1 = 4'(d); ld_s10 = 4'(e); ld_s1 = 4'(f); ld_pm = p;
   endtask

   // One-cycle load strobe followed by n enabled cycles.
   task automatic load_then_run(int a, int b, int c, int d, int e, int f, bit p, int n);
      set_ld(a, b, c, d, e, f, p);
      load = 1'b1; en = 1'b1;
      step();
      load = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      int sec_r, min_r, hr_r;
      rst = 1'b1; en = 1'b0; load = 1'b0;
      set_ld(0, 0, 0, 0, 0, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         t_m[m] = 0; presc_m[m] = 0; err_m[m] = 1'b0;
      end
      step();
      check("reset 24h", observed(0), pack(0, 0, 0, 1'b0));
      check("reset 12h", observed(1), pack(12, 0, 0, 1'b0));
      rst = 1'b0;

      // Free run from reset: four seconds in sixteen cycles.
      en = 1'b1;
      repeat (16) step();
      check("run 16 24h", observed(0), pack(0, 0, 4, 1'b0));
      check("run 16 12h", observed(1), pack(12, 0, 4, 1'b0));

      // Day wrap in 24h mode.
      load_then_run(2, 3, 5, 9, 5, 9, 1'b0, 4);
      check("23:59:59 wrap", observed(0), pack(0, 0, 0, 1'b0));

      // 11:59:59 AM -> 12:00:00 PM.
      load_then_run(1, 1, 5, 9, 5, 9, 1'b0, 4);
      check("11->12 pm", observed(1), pack(12, 0, 0, 1'b1));

      // 12:59:59 PM -> 01:00:00 PM.
      load_then_run(1, 2, 5, 9, 5, 9, 1'b1, 4);
      check("12->01 pm", observed(1), pack(1, 0, 0, 1'b1));

      // Illegal loads are rejected with a one-cycle error pulse.
      load_then_run(2, 4, 0, 0, 0, 0, 1'b0, 0);
      check("24:00 err", {31'd0, err_a}, 32'd1);
      step();
      load_then_run(0, 5, 6, 0, 0, 0, 1'b0, 0);
      check("min_10=6 err", {31'd0, err_a}, 32'd1);
      repeat (6) step();

      // Load in the same cycle as a tick.
      for (int i = 0; i < 8 && presc_m[0] != DIV - 1; i++) step();
      load_then_run(1, 0, 2, 0, 3, 0, 1'b1, 0);
      check("load on tick", observed(0), pack(10, 20, 30, 1'b0));
      repeat (4) step();
      check("tick after load", observed(0), pack(10, 20, 31, 1'b0));

      // Disable holds everything.
      en = 1'b0;
      repeat (10) step();
      check("en=0 hold", observed(0), pack(10, 20, 31, 1'b0));

      // Reset mid-second, overriding a load.
      en = 1'b1;
      for (int i = 0; i < 8 && presc_m[0] != 2; i++) step();
      set_ld(0, 9, 0, 9, 0, 9, 1'b1);
      rst = 1'b1; load = 1'b1;
      step();
      rst = 1'b0; load = 1'b0;
      check("rst over load", observed(1), pack(12, 0, 0, 1'b0));
      repeat (4) step();
      check("first tick after rst", observed(0), pack(0, 0, 1, 1'b0));

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         en   = ($urandom_range(0, 9) != 0);
         load = ($urandom_range(0, 19) == 0);
         rst  = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 3) == 0) begin
            set_ld($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   1'($urandom_range(0, 1)));
         end else begin
            hr_r  = $urandom_range(0, 23);
            min_r = (n % 5 == 0) ? 59 : $urandom_range(0, 59);
            sec_r = (n % 3 == 0) ? 59 : $urandom_range(0, 59);
            set_ld(hr_r / 10, hr_r % 10, min_r / 10, min_r % 10, sec_r / 10, sec_r % 10,
                   1'($urandom_range(0, 1)));
         end
         step();
      end
      rst = 1'b0; load = 1'b0; en = 1'b1;
      repeat (8) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bcd_timekeeper.md
BCD_TIMEKEEPER -- requirements
Module: bcd_timekeeper

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000000, clk cycles per one-second tick (legal range 2..2^32-1).
REQ-002 SHALL have parameter MODE_12H, default 0; 0 = 24-hour mode, 1 = 12-hour mode with AM/PM.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  count enable; 0 freezes prescaler and time.
REQ-006 SHALL have port load  input  1  one-cycle time-set strobe.
REQ-007 SHALL have port ld_hour_10, ld_hour1, ld_min_10, ld_min1, ld_sec_10, ld_sec1  input  4 each  BCD load digits.
REQ-008 SHALL have port ld_pm  input  1  PM flag for load; ignored when MODE_12H=0.
REQ-009 SHALL have port hour_10, hour1, min_10, min1, sec_10, sec1  output  4 each  registered BCD time digits.
REQ-010 SHALL have port pm  output  1  registered PM flag; constant 0 when MODE_12H=0.
REQ-011 SHALL have port tick_1hz  output  1  one-cycle pulse per elapsed second.
REQ-012 SHALL have port load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-013 Prescaler SHALL count 0..CLK_DIV-1 while en=1; at CLK_DIV-1 it SHALL wrap to 0 and assert tick_1hz for exactly that cycle.
REQ-014 With en=0, prescaler, digits and pm SHALL hold; tick_1hz SHALL be 0.
REQ-015 Time digits SHALL update on the clock edge following tick_1hz assertion (latency 1 cycle from tick, CLK_DIV cycles per second).
REQ-016 On tick: sec1 SHALL increment 0..9, wrapping to 0 with carry into sec_10 (0..5); 59 s SHALL wrap to 00 with carry into minutes.
REQ-017 Minutes SHALL follow the same 00..59 rule with carry into hours only when seconds wrap.
REQ-018 24h mode: hours SHALL count 00..23 and 23:59:59 SHALL wrap to 00:00:00.
REQ-019 12h mode: hours SHALL sequence 12,01,02..11,12; the 11:59:59->12:00:00 transition SHALL toggle pm; 12:59:59 SHALL go to 01:00:00 without toggling pm.
REQ-020 Load SHALL be accepted only if all digits are valid BCD for the mode: sec/min tens<=5, units<=9; 24h hour 00..23; 12h hour 01..12.
REQ-021 Accepted load SHALL write all digits (and pm in 12h mode) on the next edge and clear the prescaler to 0; any tick that cycle SHALL be discarded.
REQ-022 Rejected load SHALL leave time, pm and prescaler unchanged and pulse load_err for one cycle; counting SHALL continue normally.
REQ-023 load SHALL take effect regardless of en.
REQ-024 All outputs SHALL hold only legal BCD time values at every cycle.

Reset
REQ-025 rst=1 SHALL, on the next edge, override load and en and set prescaler 0, tick_1hz 0, load_err 0, pm 0.
REQ-026 Reset time SHALL be 00:00:00 in 24h mode and 12:00:00 (pm=0) in 12h mode.
REQ-027 Reset asserted mid-second SHALL discard the partial prescaler count; first tick SHALL occur CLK_DIV cycles after rst deasserts with en=1.

Structure
REQ-028 Package watch_pkg SHALL hold the BCD digit type (4 bits), limit constants (SEC_TENS_MAX=5, UNITS_MAX=9, HOUR24_MAX=23, HOUR12_MIN=1, HOUR12_MAX=12) and the hour-mode enumeration.
REQ-029 Prescaler SHALL be a sub-module tick_gen (parameter CLK_DIV; ports clk, rst, en, clr, tick); digit cascade and load checking SHALL stay in bcd_timekeeper.
REQ-030 Prescaler width SHALL be $clog2(CLK_DIV).

Verification (CLK_DIV=4 unless stated)
REQ-031 Reset, en=1 for 16 cycles -> tick_1hz every 4th cycle, time 00:00:04.
REQ-032 Load 23:59:59 (24h), one tick -> 00:00:00; load 11:59:59 pm=0 (12h), one tick -> 12:00:00 pm=1.
REQ-033 12h load 12:59:59 pm=1, one tick -> 01:00:00 pm=1.
REQ-034 Load 24:00:00 (24h) or min_10=6 -> load_err one cycle, time unchanged, counting continues.
REQ-035 Load coincident with tick -> loaded value shown, no increment, next tick 4 cycles later; en=0 for 10 cycles -> no change, no tick.
REQ-036 rst asserted at prescaler=2 with load=1 -> reset values, first tick 4 cycles after release.
